// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Definitions shared by the packed-BCD to binary converter:
//   - state_t         : converter FSM states (IDLE, CONV, DONE)
//   - BCD_ADJ_THRESH  : a digit at or above this value after a shift needs correction
//   - BCD_ADJ_VAL     : the correction that is subtracted from such a digit
//   - BCD_MAX_DIGIT   : the largest legal BCD digit
//   - calc_bw()       : binary width needed for NDIG decimal digits, $clog2(10**NDIG)
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

    // Smallest w with 2**w >= 10**ndig. 10**ndig is never a power of two,
    // so this is exactly the bit count that holds 10**ndig - 1.
    function automatic int calc_bw(input int ndig);
        logic [63:0] p;
        int          w;
        p = 64'd1;
        for (int i = 0; i < ndig; i++) begin
            p = p * 64'd10;
        end
        w = 0;
        for (int i = 0; i < 40; i++) begin
            if ((64'd1 << i) < p) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_if
// Handshake bundle of the BCD to binary converter.
// Parameter NDIG : number of BCD digits (1..6); BW is derived from it.
// Signals:
//   in_valid  : producer has a value on in_bcd
//   in_ready  : converter can accept a value
//   in_bcd    : packed BCD, most significant digit in the top nibble
//   out_valid : out_bin/out_err hold a result, held until accepted
//   out_ready : consumer takes the result
//   out_bin   : binary result
//   out_err   : an input digit was above 9 (only with BCD_DIGIT_CHECK_EN)
// Modports: master = producer/consumer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd_to_bin_if #(
    parameter int NDIG = 4
);
    localparam int BW = bcd_pkg::calc_bw(NDIG);

    logic                in_valid;
    logic                in_ready;
    logic [4*NDIG-1:0]   in_bcd;
    logic                out_valid;
    logic                out_ready;
    logic [BW-1:0]       out_bin;
    logic                out_err;

    modport master (
        output in_valid,
        output in_bcd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bin,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_bcd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bin,
        output out_err
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational correction of one BCD digit after a right shift: a bit
// shifted in from the next-higher digit arrives with weight 8 but is worth
// 10/2 = 5, so any digit >= 8 is reduced by 3. No borrow leaves the nibble.
// Ports:
//   din  : digit nibble after the shift
//   dout : corrected nibble
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THRESH) ? (din - BCD_ADJ_VAL) : din;

endmodule

// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
// Sequential packed-BCD to binary converter (reverse double-dabble).
// The work register S = {bcd, bin} is shifted right once per cycle and each
// BCD digit is then corrected; after BW shifts the bin field holds the value.
// Result appears BW clock edges after the accepting edge.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : bcd_to_bin_if.slave (in_valid/in_ready/in_bcd,
//         out_valid/out_ready/out_bin/out_err)
// Parameter:
//   NDIG : number of BCD digits (1..6); BW = $clog2(10**NDIG)
// Build option:
//   BCD_DIGIT_CHECK_EN : when defined, out_err flags an input digit > 9 and
//                        out_bin is forced to 0 for that conversion. When
//                        undefined, out_err is always 0.
// -----------------------------------------------------------------------------
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
)(
    input  logic          clk,
    input  logic          rst,
    bcd_to_bin_if.slave   bus
);

    localparam int BW = calc_bw(NDIG);
    localparam int DW = 4 * NDIG;
    localparam int SW = DW + BW;
    localparam int CW = $clog2(BW + 1);
    localparam logic [CW-1:0] LAST = CW'(BW - 1);

    state_t          state;
    logic [SW-1:0]   s_q;
    logic [SW-1:0]   s_shift;
    logic [SW-1:0]   s_next;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bin_q;
    logic            out_valid_q;
    logic            err_q;
    logic            err_in;

    // One reverse double-dabble step: shift, then correct every digit.
    assign s_shift = s_q >> 1;
    assign s_next[BW-1:0] = s_shift[BW-1:0];

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (s_shift[BW + 4*g +: 4]),
            .dout (s_next[BW + 4*g +: 4])
        );
    end

`ifdef BCD_DIGIT_CHECK_EN
    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.in_bcd[4*i +: 4] > BCD_MAX_DIGIT) begin
                err_in = 1'b1;
            end
        end
    end
`else
    assign err_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s_q         <= '0;
            cnt         <= '0;
            bin_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high whenever we are here with rst low
                    if (bus.in_valid) begin
                        s_q   <= {bus.in_bcd, {BW{1'b0}}};
                        cnt   <= '0;
                        err_q <= err_in;
                        state <= CONV;
                    end
                end
                CONV: begin
                    s_q <= s_next;
                    cnt <= cnt + 1'b1;
                    // cnt counts completed steps; the step taken at LAST is the BW-th
                    if (cnt == LAST) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        bin_q       <= err_q ? '0 : s_next[BW-1:0];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = bin_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin
// Self-checking bench for bcd_to_bin (NDIG = 4, BW = 14): a table of fixed
// vectors, hand-written handshake/reset sequences, and random BCD values
// checked against an arithmetic decimal model plus a binary-to-BCD round trip.
// Build option BCD_DIGIT_CHECK_EN enables the invalid-digit checks.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin;

    localparam int NDIG = 4;
    localparam int BW   = bcd_pkg::calc_bw(NDIG);
    localparam int DW   = 4 * NDIG;

    logic clk;
    logic rst;

    int n_vec;
    int n_miss;

    bcd_to_bin_if #(.NDIG(NDIG)) bif ();

    bcd_to_bin #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] bcd;
        logic [BW-1:0] bin;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Decimal value of a packed BCD word, by plain positional arithmetic.
    function automatic int ref_value(input logic [DW-1:0] bcd);
        int v, w;
        v = 0;
        w = 1;
        for (int i = 0; i < NDIG; i++) begin
            v = v + int'(bcd[4*i +: 4]) * w;
            w = w * 10;
        end
        return v;
    endfunction

    function automatic logic ref_err(input logic [DW-1:0] bcd);
        logic e;
        e = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    // Display-path direction: binary back to packed BCD.
    function automatic logic [DW-1:0] bin_to_bcd(input int v);
        logic [DW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (!bif.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_accept", 32'(bif.in_ready), 32'd1);
    endtask

    // Full transaction; returns result, error flag and edges from accept to out_valid.
    task automatic convert(input logic [DW-1:0] bcd, output logic [BW-1:0] bin,
                           output logic err, output int lat);
        wait_ready();
        bif.in_bcd   = bcd;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.in_bcd   = DW'($urandom);
        lat = 0;
        while (!bif.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        bin = bif.out_bin;
        err = bif.out_err;
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
    endtask

    initial begin
        logic [BW-1:0] bin;
        logic [BW-1:0] held;
        logic          err;
        logic [DW-1:0] bcd;
        int            lat;

        n_vec  = 0;
        n_miss = 0;
        bif.in_valid  = 1'b0;
        bif.in_bcd    = '0;
        bif.out_ready = 1'b0;
        rst = 1'b1;

        tbl[0] = '{16'h9999, 14'd9999};
        tbl[1] = '{16'h0000, 14'd0};
        tbl[2] = '{16'h0255, 14'd255};
        tbl[3] = '{16'h1234, 14'd1234};
        tbl[4] = '{16'h0001, 14'd1};
        tbl[5] = '{16'h1000, 14'd1000};
        tbl[6] = '{16'h9000, 14'd9000};
        tbl[7] = '{16'h0999, 14'd999};
        tbl[8] = '{16'h5050, 14'd5050};
        tbl[9] = '{16'h8008, 14'd8008};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bif.in_ready), 32'd0);
        check("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("rst_out_bin", 32'(bif.out_bin), 32'd0);
        check("rst_out_err", 32'(bif.out_err), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bif.in_ready), 32'd1);

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            convert(tbl[i].bcd, bin, err, lat);
            check("tbl_latency", 32'(lat), 32'(BW));
            check("tbl_bin", 32'(bin), 32'(tbl[i].bin));
            check("tbl_err", 32'(err), 32'd0);
        end

        // Backpressure: result held for 5 cycles with out_ready low
        wait_ready();
        bif.in_bcd = 16'h4321;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        lat = 0;
        while (!bif.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(BW));
        held = bif.out_bin;
        check("bp_bin", 32'(held), 32'd4321);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(bif.out_valid), 32'd1);
            check("bp_hold_bin", 32'(bif.out_bin), 32'd4321);
            check("bp_hold_in_ready", 32'(bif.in_ready), 32'd0);
        end
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        check("bp_after_valid", 32'(bif.out_valid), 32'd0);
        check("bp_after_in_ready", 32'(bif.in_ready), 32'd1);

        // in_valid held with changing in_bcd; out_ready high before DONE
        wait_ready();
        bif.in_bcd = 16'h0777;
        bif.in_valid = 1'b1;
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!bif.out_valid && lat < 100) begin
            bif.in_bcd = bin_to_bcd($urandom_range(0, 9999));
            @(posedge clk); #1;
            lat++;
        end
        bif.in_valid = 1'b0;
        check("hold_latency", 32'(lat), 32'(BW));
        check("hold_bin", 32'(bif.out_bin), 32'd777);
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        check("hold_xfer_valid", 32'(bif.out_valid), 32'd0);
        check("hold_xfer_in_ready", 32'(bif.in_ready), 32'd1);

        // Reset pulsed mid-CONV
        bif.in_bcd = 16'h8888;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bif.in_ready), 32'd0);
        check("midrst_valid", 32'(bif.out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_rel_in_ready", 32'(bif.in_ready), 32'd1);
        check("midrst_rel_valid", 32'(bif.out_valid), 32'd0);
        convert(16'h1234, bin, err, lat);
        check("midrst_next_bin", 32'(bin), 32'd1234);
        check("midrst_next_latency", 32'(lat), 32'(BW));

        // Reset asserted while in DONE discards the result
        wait_ready();
        bif.in_bcd = 16'h0042;
        bif.in_valid = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        repeat (BW) @(posedge clk);
        #1;
        check("donerst_pre_valid", 32'(bif.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("donerst_valid", 32'(bif.out_valid), 32'd0);
        check("donerst_bin", 32'(bif.out_bin), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("donerst_in_ready", 32'(bif.in_ready), 32'd1);

`ifdef BCD_DIGIT_CHECK_EN
        convert(16'h12A4, bin, err, lat);
        check("chk_bad_err", 32'(err), 32'd1);
        check("chk_bad_bin", 32'(bin), 32'd0);
        check("chk_bad_latency", 32'(lat), 32'(BW));
        convert(16'h0042, bin, err, lat);
        check("chk_good_err", 32'(err), 32'd0);
        check("chk_good_bin", 32'(bin), 32'd42);
`endif

        // Random values against the decimal model and the round trip
        for (int n = 0; n < 300; n++) begin
            bcd = '0;
            for (int d = 0; d < NDIG; d++) begin
`ifdef BCD_DIGIT_CHECK_EN
                bcd[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
`else
                bcd[4*d +: 4] = 4'($urandom_range(0, 9));
`endif
            end
            convert(bcd, bin, err, lat);
            check("rnd_latency", 32'(lat), 32'(BW));
            if (ref_err(bcd)) begin
                check("rnd_err_flag", 32'(err), 32'd1);
                check("rnd_err_bin", 32'(bin), 32'd0);
            end else begin
                check("rnd_err", 32'(err), 32'd0);
                check("rnd_bin", 32'(bin), 32'(ref_value(bcd)));
                check("rnd_roundtrip", 32'(bin_to_bcd(int'(bin))), 32'(bcd));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
